// File: rtl/nonce_scanner_if.sv
// Byte-serial header load channel between a header source and the nonce scanner.
// The source drives valid/data; the scanner answers with ready.
interface nonce_scanner_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/nonce_scanner.sv
// Mining controller: assembles an 80-byte header, sweeps the little-endian nonce through a SHA core,
// and stops on a leading-zero hit, on nonce exhaustion or on abort. Define SCAN_LIMIT_EN for a nonce_end limit.
module nonce_scanner #(
    parameter int          KICK_LEN   = 1,
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    nonce_scanner_if.slave      ld,
    input  logic                start,
    input  logic                abort,
    input  logic [31:0]         nonce_start,
    input  logic [7:0]          zbits,
`ifdef SCAN_LIMIT_EN
    input  logic [31:0]         nonce_end,
`endif
    output logic [639:0]        block,
    output logic                sha_rst_n,
    input  logic [255:0]        hash_in,
    input  logic                hash_done,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic [31:0]         nonce_out
);

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam logic [6:0] LAST_BYTE = 7'd75;
    localparam logic [3:0] KICK_LAST = 4'(KICK_LEN - 1);

    state_t         state_reg;
    logic [639:0]   block_reg;
    logic [6:0]     byte_cnt_reg;
    logic           hdr_loaded_reg;
    logic [3:0]     kick_cnt_reg;
    logic [7:0]     zbits_reg;
    logic           sha_rst_n_reg;
    logic           busy_reg;
    logic           found_reg;
    logic           exhausted_reg;
    logic           load_ready_reg;
    logic [31:0]    nonce_out_reg;
`ifdef SCAN_LIMIT_EN
    logic [31:0]    nonce_end_reg;
`endif

    logic           load_fire;
    logic [9:0]     byte_msb;
    logic [31:0]    nonce_le;
    logic [255:0]   hash_rev;
    logic [255:0]   zero_mask;
    logic           hit;
    logic [32:0]    nonce_sum;
    logic           last_nonce;

    assign load_fire = ld.load_valid && load_ready_reg;
    // Byte k of the header lands at the top of the block, MSB-first.
    assign byte_msb  = 10'd639 - {byte_cnt_reg, 3'b000};

    // Nonce is stored little-endian in the last header word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nonce_le
            assign nonce_le[31-8*gi -: 8] = nonce_out_reg[8*gi +: 8];
        end
        for (gi = 0; gi < 32; gi++) begin : g_hash_rev
            assign hash_rev[255-8*gi -: 8] = hash_in[8*gi +: 8];
        end
    endgenerate

    // Top zbits of the byte-reversed digest must all be zero; zbits==0 yields an empty mask.
    assign zero_mask = ~({256{1'b1}} >> zbits_reg);
    assign hit       = ((hash_rev & zero_mask) == 256'd0);

    assign nonce_sum = {1'b0, nonce_out_reg} + {1'b0, NONCE_STEP};
`ifdef SCAN_LIMIT_EN
    assign last_nonce = nonce_sum[32] || (nonce_out_reg >= nonce_end_reg);
`else
    assign last_nonce = nonce_sum[32];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            block_reg      <= '0;
            byte_cnt_reg   <= '0;
            hdr_loaded_reg <= 1'b0;
            kick_cnt_reg   <= '0;
            zbits_reg      <= '0;
            sha_rst_n_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            found_reg      <= 1'b0;
            exhausted_reg  <= 1'b0;
            load_ready_reg <= 1'b1;
            nonce_out_reg  <= '0;
`ifdef SCAN_LIMIT_EN
            nonce_end_reg  <= '0;
`endif
        end else begin
            if (load_fire) begin
                block_reg[byte_msb -: 8] <= ld.load_data;
                found_reg                <= 1'b0;
                exhausted_reg            <= 1'b0;
                if (byte_cnt_reg == LAST_BYTE) begin
                    byte_cnt_reg   <= '0;
                    hdr_loaded_reg <= 1'b1;
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 7'd1;
                end
            end

            if (abort && busy_reg) begin
                state_reg      <= IDLE;
                sha_rst_n_reg  <= 1'b0;
                busy_reg       <= 1'b0;
                load_ready_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (start && !abort && hdr_loaded_reg) begin
                            state_reg      <= KICK;
                            nonce_out_reg  <= nonce_start;
                            zbits_reg      <= zbits;
`ifdef SCAN_LIMIT_EN
                            nonce_end_reg  <= nonce_end;
`endif
                            found_reg      <= 1'b0;
                            exhausted_reg  <= 1'b0;
                            sha_rst_n_reg  <= 1'b0;
                            kick_cnt_reg   <= '0;
                            busy_reg       <= 1'b1;
                            load_ready_reg <= 1'b0;
                        end
                    end
                    KICK: begin
                        block_reg[31:0] <= nonce_le;
                        if (kick_cnt_reg == KICK_LAST) begin
                            sha_rst_n_reg <= 1'b1;
                            state_reg     <= WAIT;
                        end else begin
                            kick_cnt_reg <= kick_cnt_reg + 4'd1;
                        end
                    end
                    WAIT: begin
                        if (hash_done) begin
                            state_reg <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (hit || last_nonce) begin
                            found_reg      <= hit;
                            exhausted_reg  <= !hit;
                            state_reg      <= DONE;
                            busy_reg       <= 1'b0;
                            load_ready_reg <= 1'b1;
                        end else begin
                            nonce_out_reg <= nonce_sum[31:0];
                            sha_rst_n_reg <= 1'b0;
                            kick_cnt_reg  <= '0;
                            state_reg     <= KICK;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ld.load_ready = load_ready_reg;
    assign block         = block_reg;
    assign sha_rst_n     = sha_rst_n_reg;
    assign busy          = busy_reg;
    assign found         = found_reg;
    assign exhausted     = exhausted_reg;
    assign nonce_out     = nonce_out_reg;

endmodule

// File: doc/nonce_scanner.md
Name: nonce_scanner

Overview:
- Mining controller directly upstream of the sha256 core.
- Assembles the 640-bit block header from a byte-serial load port and inserts a little-endian nonce.
- Restarts the core for each attempt, then checks the returned double-SHA256 digest against a leading-zero difficulty.
- Scans nonces until it finds a hit, runs out of nonces, or is aborted.

Parameters:
- KICK_LEN, 1: cycles sha_rst_n is held low per attempt (1..15).
- NONCE_STEP, 1: increment applied to the nonce between attempts.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  header byte valid
- load_data  in  8  header byte
- load_ready  out  1  loader can accept a byte
- start  in  1  begin scan (1-cycle pulse)
- abort  in  1  stop scan, return to IDLE
- nonce_start  in  32  first nonce, sampled on start
- zbits  in  8  required leading zero bits, sampled on start
- block  out  640  header to core, registered
- sha_rst_n  out  1  core reset, registered
- hash_in  in  256  core hash output
- hash_done  in  1  core done flag
- busy  out  1  scan in progress
- found  out  1  hit, sticky until next start/load/reset
- exhausted  out  1  nonce space ended without hit, sticky
- nonce_out  out  32  nonce of current/last attempt

Behaviour:
- Reset values:
  - load_ready=1, block=0, sha_rst_n=0, busy=0, found=0, exhausted=0, nonce_out=0.
  - Byte counter = 0; hdr_loaded = 0; state = IDLE.
- Load:
  - Accept a byte when load_valid && load_ready.
  - load_ready=1 in IDLE/DONE only.
  - Byte k (0..75) is written to block[639-8k -: 8].
  - Any accepted byte clears found/exhausted.
  - The 76th byte sets hdr_loaded and wraps the counter to 0.
  - Bytes offered while busy are not accepted.
- States: IDLE, KICK, WAIT, CHECK, DONE. busy=1 in KICK/WAIT/CHECK.
- IDLE/DONE:
  - start && hdr_loaded → KICK: nonce_out<=nonce_start, latch zbits, clear found/exhausted.
  - start without hdr_loaded is ignored.
- KICK:
  - block[31:0] <= {n[7:0], n[15:8], n[23:16], n[31:24]} of nonce_out.
  - sha_rst_n=0 for exactly KICK_LEN cycles, then 1 → WAIT.
- WAIT: hash_done=1 → CHECK. No timeout.
- CHECK (1 cycle):
  - r = byte-reversed hash_in, i.e. {hash_in[7:0], hash_in[15:8], …, hash_in[255:248]}.
  - Hit iff zbits==0 or r[255 -: zbits]==0.
  - Hit → found=1, DONE; nonce_out holds the winning nonce.
  - Miss and nonce_out is the final nonce → exhausted=1, DONE.
  - Else nonce_out += NONCE_STEP (mod 2^32) → KICK.
- Final nonce: the one for which nonce_out + NONCE_STEP would wrap past 0xFFFFFFFF.
- DONE: sha_rst_n stays 1; core output is left intact.
- abort:
  - Has priority in any busy state: next cycle state=IDLE, sha_rst_n=0.
  - found/exhausted unchanged; nonce_out holds the last attempted nonce.
  - start and abort in the same cycle: abort wins.
- block is stable from KICK exit to CHECK; it changes only in KICK or on load.
- Asynchronous reset mid-scan or mid-load returns every register to its reset value; a partial header is discarded.

Optional Feature:
- Macro: SCAN_LIMIT_EN.
- When defined:
  - Extra input nonce_end[31:0], sampled on start.
  - The final nonce is the first attempted nonce ≥ nonce_end, or the natural wrap point, whichever comes first.
- When undefined: no port; scan runs to the 2^32 wrap only.

Test Plan:
- Load bytes 0x00..0x4B, zbits=0, nonce_start=0x12345678, start → one attempt; found=1; nonce_out=0x12345678; block[639:632]=0x00; block[39:32]=0x4B; block[31:0]=0x78563412.
- Stub core: digest last byte 0x00 only for nonce 5, else 0xFF; zbits=8, nonce_start=0 → six attempts, found=1, nonce_out=5, sha_rst_n low KICK_LEN cycles each attempt.
- nonce_start=0xFFFFFFFE, stub never hits → two attempts, exhausted=1, found=0, nonce_out=0xFFFFFFFF, busy=0.
- abort during WAIT → IDLE next cycle, sha_rst_n=0, load_ready=1; start again → scan restarts from new nonce_start.
- Reset after 40 bytes loaded, then start → ignored (busy stays 0); full reload + start works. start with abort in the same cycle → stays IDLE.
- With SCAN_LIMIT_EN: nonce_start=10, nonce_end=12, no hits → attempts 10, 11, 12, then exhausted=1, nonce_out=12.
